minibus_sram_slave: RTL and testbench

- Single-port word-addressed SRAM responder on the minibus. It is the decoder/responder side of the bus, the counterpart to a minibus master.
- Accepts one read or write request at a time and inserts a programmable number of wait states.
- Returns read data or an error with a one-cycle ready pulse.
- Sits behind the minibus address decoder as the backing store for instruction/data memory in CPU-X test systems.

---
 rtl/minibus_sram_slave.sv | 120 ++++++++++++
 tb/tb_minibus_sram_slave.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minibus_sram_slave.sv
// Minibus SRAM responder: word-addressed single-port store with
// programmable wait states and a one-cycle ready/error response.
module minibus_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        res_ready,
  output logic [31:0] res_rdata,
  output logic        res_error
);

  localparam int         AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_err;
  logic          r_wr;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic [32:0]   w_off;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_accept;
  logic          w_we;

  assign w_req    = req_ren | req_wen;
  assign w_off    = {1'b0, req_addr} - {1'b0, ADDR_BASE};
  assign w_err    = (req_ren & req_wen)
                  | (req_addr[1:0] != 2'b00)
                  | (req_addr < ADDR_BASE)
                  | (w_off >= LIMIT);
  assign w_idx    = w_off[AW+1:2];
  assign w_accept = (r_state == S_IDLE) & w_req;
  assign w_we     = (r_state == S_RESP) & r_wr & ~r_err;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_cnt_nxt = WC;
          w_next    = (WC == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // Master dropped its request mid-transaction: abandon silently.
        if (!w_req) begin
          w_next    = S_IDLE;
          w_cnt_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_next = S_RESP;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_err <= w_err;
        r_wr  <= req_wen;
      end
    end
  end

  // Array is read at acceptance; no write can land before RESP.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= w_idx;
      r_rdata <= r_mem[w_idx];
    end
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) r_mem[r_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign res_ready = (r_state == S_RESP);
  assign res_error = res_ready & r_err;
  assign res_rdata = (res_ready & ~r_err & ~r_wr) ? r_rdata : 32'h0;

endmodule

// File: tb/tb_minibus_sram_slave.sv
// Bench for minibus_sram_slave: vector table, corner sequences and
// randomized traffic on three instances checked against a memory model.
module tb_minibus_sram_slave;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        rdy   [3];
  logic [31:0] rdat  [3];
  logic        errq  [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  minibus_sram_slave #(
    .ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)
  ) u0 (
    .clk(clk), .nrst(nrst),
    .req_ren(ren[0]), .req_wen(wen[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .req_wstrb(wstrb[0]),
    .res_ready(rdy[0]), .res_rdata(rdat[0]), .res_error(errq[0])
  );

  minibus_sram_slave #(
    .ADDR_BASE(32'h100), .DEPTH_WORDS(16), .WAIT_CYCLES(0)
  ) u1 (
    .clk(clk), .nrst(nrst),
    .req_ren(ren[1]), .req_wen(wen[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .req_wstrb(wstrb[1]),
    .res_ready(rdy[1]), .res_rdata(rdat[1]), .res_error(errq[1])
  );

  minibus_sram_slave #(
    .ADDR_BASE(32'h0), .DEPTH_WORDS(64), .WAIT_CYCLES(3)
  ) u2 (
    .clk(clk), .nrst(nrst),
    .req_ren(ren[2]), .req_wen(wen[2]), .req_addr(addr[2]),
    .req_wdata(wdata[2]), .req_wstrb(wstrb[2]),
    .res_ready(rdy[2]), .res_rdata(rdat[2]), .res_error(errq[2])
  );

  function automatic logic [31:0] base_of(int i);
    return (i == 1) ? 32'h100 : 32'h0;
  endfunction

  function automatic int depth_of(int i);
    return (i == 0) ? 1024 : (i == 1) ? 16 : 64;
  endfunction

  function automatic int wait_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  // Reference memory, indexed by word offset from each instance's base.
  logic [31:0] mm [3][1024];

  function automatic logic merr(int i, logic r, logic w, logic [31:0] a);
    longint off;
    off = longint'({32'b0, a}) - longint'({32'b0, base_of(i)});
    return (r && w) || (a % 4 != 0) || (off < 0) ||
           (off >= longint'(depth_of(i)) * 4);
  endfunction

  function automatic int midx(int i, logic [31:0] a);
    return int'((a - base_of(i)) / 4);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int i, logic r, logic w, logic [31:0] a,
                       logic [31:0] d, logic [3:0] s);
    ren[i] = r; wen[i] = w; addr[i] = a; wdata[i] = d; wstrb[i] = s;
  endtask

  task automatic clear(int i);
    ren[i] = 1'b0; wen[i] = 1'b0;
  endtask

  task automatic txn(input int i, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int lat,
                     output logic [31:0] rd, output logic e,
                     output int rc);
    drive(i, r, w, a, d, s);
    lat = -1; rd = 32'h0; e = 1'b0; rc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rdy[i]) begin
        lat = c; rd = rdat[i]; e = errq[i]; rc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic mtxn(input int i, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int gap,
                      output int rc);
    logic        ee;
    logic [31:0] erd;
    int          lat;
    logic [31:0] rd;
    logic        e;
    int          k;
    ee  = merr(i, r, w, a);
    erd = 32'h0;
    k   = 0;
    if (!ee) k = midx(i, a);
    if (!ee && r) erd = mm[i][k];
    txn(i, r, w, a, d, s, lat, rd, e, rc);
    chk($sformatf("latency i%0d a%h", i, a), lat, wait_of(i) + 1);
    chk($sformatf("error i%0d a%h", i, a), {31'b0, e}, {31'b0, ee});
    if (r || ee) chk($sformatf("rdata i%0d a%h", i, a), rd, erd);
    if (!ee && w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) mm[i][k][8*b +: 8] = d[8*b +: 8];
    end
    if (gap > 0) begin
      clear(i);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        e;
    logic [31:0] rd;
    logic        chkd;
  } vec_t;

  vec_t vt[$];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    int          rc;
    int          rcs[4];
    int          bad;
    logic [31:0] old;

    vt.push_back('{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1});
    vt.push_back('{1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h20, 32'h11223344, 4'h5, 1'b0, 32'h0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h1002, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1});
    vt.push_back('{1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1});
    vt.push_back('{1'b0, 1'b1, 32'h12, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1});
    vt.push_back('{1'b0, 1'b1, 32'h0, 32'hAAAA5555, 4'hF, 1'b0, 32'h0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 32'h1000, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1});
    vt.push_back('{1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hAAAA5555, 1'b1});
    vt.push_back('{1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hDE22BE44, 1'b1});

    nrst = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ready i%0d", i), {31'b0, rdy[i]}, 32'h0);
      chk($sformatf("reset rdata i%0d", i), rdat[i], 32'h0);
      chk($sformatf("reset error i%0d", i), {31'b0, errq[i]}, 32'h0);
    end
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;

    foreach (vt[n]) begin
      txn(0, vt[n].r, vt[n].w, vt[n].a, vt[n].d, vt[n].s, lat, rd, e, rc);
      chk($sformatf("vec%0d latency", n), lat, 2);
      chk($sformatf("vec%0d error", n), {31'b0, e}, {31'b0, vt[n].e});
      if (vt[n].chkd) chk($sformatf("vec%0d rdata", n), rd, vt[n].rd);
      clear(0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 16; k++)
        mtxn(i, 1'b0, 1'b1, base_of(i) + 32'(4 * k), $urandom, 4'hF, 1, rc);

    for (int k = 0; k < 4; k++)
      mtxn(1, 1'b1, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0, 0, rcs[k]);
    clear(1);
    @(posedge clk); #1;
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b spacing %0d", k), rcs[k] - rcs[k-1], 2);

    old = mm[2][5];
    drive(2, 1'b0, 1'b1, 32'h14, ~old, 4'hF);
    @(negedge clk);
    chk("abort c0 ready", {31'b0, rdy[2]}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort c1 ready", {31'b0, rdy[2]}, 32'h0);
    @(posedge clk); #1;
    clear(2);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[2]) bad++;
      @(posedge clk); #1;
    end
    chk("abort no ready", bad, 0);
    mtxn(2, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1, rc);

    old = mm[2][6];
    drive(2, 1'b0, 1'b1, 32'h18, ~old, 4'hF);
    repeat (3) begin @(posedge clk); #1; end
    nrst = 1'b0;
    #1;
    chk("rst wait ready", {31'b0, rdy[2]}, 32'h0);
    chk("rst wait error", {31'b0, errq[2]}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    clear(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mtxn(2, 1'b1, 1'b0, 32'h18, 32'h0, 4'h0, 1, rc);

    drive(0, 1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp ready", {31'b0, rdy[0]}, 32'h1);
    chk("resp rdata", rdat[0], mm[0][3]);
    nrst = 1'b0;
    #1;
    chk("rst resp ready", {31'b0, rdy[0]}, 32'h0);
    chk("rst resp rdata", rdat[0], 32'h0);
    chk("rst resp error", {31'b0, errq[0]}, 32'h0);
    clear(0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 450; n++) begin
      int          i;
      int          kind;
      int          op;
      logic [31:0] a;
      logic        r;
      logic        w;
      i    = $urandom_range(0, 2);
      kind = $urandom_range(0, 11);
      a    = base_of(i) + 32'(4 * $urandom_range(0, 15));
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      if (kind == 9)
        a = base_of(i) + 32'(depth_of(i) * 4) + 32'(4 * $urandom_range(0, 3));
      if (kind == 10)
        a = (i == 1) ? (32'($urandom_range(0, 255)) & ~32'h3) : 32'hFFFFFFFC;
      if (kind == 11) a = $urandom | 32'h8000_0000;
      op = $urandom_range(0, 12);
      r  = (op < 6) || (op == 12);
      w  = (op >= 6);
      mtxn(i, r, w, a, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 2), rc);
      clear(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
